// File: rtl/cableado_bit_cmp.sv
// Bit-serial unsigned magnitude comparator: one cableado bit-cell scanned LSB first.
// Optional equality output EQ is built when CABLEADO_EQ_FLAG_EN is defined.
//
// state    | meaning
// ST_IDLE  | waiting for start, result outputs held
// ST_RUN   | shifting operands through the bit-cell, one bit per clock
module cableado_bit_cmp #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         P,
    output logic         Z_out,
`ifdef CABLEADO_EQ_FLAG_EN
    output logic         EQ,
`endif
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          g_q, g_d;
    logic          z_q, z_d;
    logic          done_q, done_d;

    logic bit_a, bit_b, g_next;

    assign bit_a  = sa_q[0];
    assign bit_b  = sb_q[0];
    // Later (more significant) bits override earlier ones unless they are equal.
    assign g_next = (bit_a & ~bit_b) | (~(bit_a ^ bit_b) & g_q);

`ifdef CABLEADO_EQ_FLAG_EN
    logic eq_run_q, eq_run_d;
    logic eq_q, eq_d;
    logic eq_next;

    assign eq_next = eq_run_q & ~(bit_a ^ bit_b);
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        z_d     = z_q;
        done_d  = 1'b0;
`ifdef CABLEADO_EQ_FLAG_EN
        eq_run_d = eq_run_q;
        eq_d     = eq_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    g_d     = P;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef CABLEADO_EQ_FLAG_EN
                    eq_run_d = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                g_d   = g_next;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
`ifdef CABLEADO_EQ_FLAG_EN
                eq_run_d = eq_next;
`endif
                if (cnt_q == LAST_BIT) begin
                    z_d     = g_next;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef CABLEADO_EQ_FLAG_EN
                    eq_d = eq_next;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef CABLEADO_EQ_FLAG_EN
            eq_run_q <= 1'b0;
            eq_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            z_q     <= z_d;
            done_q  <= done_d;
`ifdef CABLEADO_EQ_FLAG_EN
            eq_run_q <= eq_run_d;
            eq_q     <= eq_d;
`endif
        end
    end

    assign Z_out = z_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
`ifdef CABLEADO_EQ_FLAG_EN
    assign EQ    = eq_q;
`endif

endmodule

// File: tb/tb_cableado_bit_cmp.sv
// Directed bench for cableado_bit_cmp (N = 16); inputs driven and outputs sampled on negedge.
module tb_cableado_bit_cmp;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A, B;
    logic         P;
    logic         Z_out, busy, done;
`ifdef CABLEADO_EQ_FLAG_EN
    logic         EQ;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cableado_bit_cmp #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .Z_out (Z_out),
`ifdef CABLEADO_EQ_FLAG_EN
        .EQ    (EQ),
`endif
        .busy  (busy),
        .done  (done)
    );

    // Issue one start pulse and wait for done; lat = negedges after the accepting edge (-1 on timeout).
    task automatic do_cmp(input logic [N-1:0] a_v, input logic [N-1:0] b_v, input logic p_v,
                          output int lat, output logic z, output logic busy_ok);
        start = 1'b1; A = a_v; B = b_v; P = p_v;
        @(negedge clk);
        start = 1'b0;
        busy_ok = busy;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        z = Z_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0; P = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({Z_out, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs: got Z/busy/done=%b expected 000", {Z_out, busy, done});
        end
`ifdef CABLEADO_EQ_FLAG_EN
        checks++;
        if (EQ !== 1'b0) begin
            failures++;
            $display("FAIL reset_eq: got %b expected 0", EQ);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic z, bok;
        do_cmp(16'h0005, 16'h0003, 1'b0, lat, z, bok);
        checks++;
        if (lat !== N) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", lat, N); end
        checks++;
        if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy: got busy_ok=%b expected 1", bok); end
        checks++;
        if (z !== 1'b1) begin failures++; $display("FAIL basic_z: got %b expected 1", z); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    endtask

    task automatic test_p_override();
        int lat; logic z, bok;
        do_cmp(16'h0003, 16'h0005, 1'b1, lat, z, bok);
        checks++;
        if (z !== 1'b0 || lat !== N) begin
            failures++; $display("FAIL p_override: got z=%b lat=%0d expected z=0 lat=%0d", z, lat, N);
        end
    endtask

    task automatic test_equal();
        int lat; logic z, bok;
        do_cmp(16'h1234, 16'h1234, 1'b1, lat, z, bok);
        checks++;
        if (z !== 1'b1) begin failures++; $display("FAIL equal_p1: got %b expected 1", z); end
`ifdef CABLEADO_EQ_FLAG_EN
        checks++;
        if (EQ !== 1'b1) begin failures++; $display("FAIL equal_p1_eq: got %b expected 1", EQ); end
`endif
        do_cmp(16'h1234, 16'h1234, 1'b0, lat, z, bok);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL equal_p0: got %b expected 0", z); end
`ifdef CABLEADO_EQ_FLAG_EN
        checks++;
        if (EQ !== 1'b1) begin failures++; $display("FAIL equal_p0_eq: got %b expected 1", EQ); end
        do_cmp(16'h1234, 16'h1235, 1'b0, lat, z, bok);
        checks++;
        if (EQ !== 1'b0) begin failures++; $display("FAIL unequal_eq: got %b expected 0", EQ); end
`endif
    endtask

    task automatic test_msb();
        int lat; logic z, bok;
        do_cmp(16'h8000, 16'h7FFF, 1'b0, lat, z, bok);
        checks++;
        if (z !== 1'b1) begin failures++; $display("FAIL msb_gt: got %b expected 1", z); end
        do_cmp(16'h7FFF, 16'h8000, 1'b1, lat, z, bok);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL msb_lt: got %b expected 0", z); end
    endtask

    task automatic test_ignore_restart();
        int lat; logic seen;
        start = 1'b1; A = 16'hFFFF; B = 16'h0000; P = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = -1; seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (i == 5) begin
                start = 1'b1; A = 16'h0000; B = 16'hFFFF; P = 1'b0;
            end else if (i == 6) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin lat = i; seen = 1'b1; break; end
        end
        checks++;
        if (!seen || lat !== N || Z_out !== 1'b1) begin
            failures++; $display("FAIL ignore_restart: got lat=%0d z=%b expected lat=%0d z=1", lat, Z_out, N);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (Z_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL hold_after_done: got z/busy/done=%b%b%b expected 100", Z_out, busy, done);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic z, bok, spurious;
        do_cmp(16'h0009, 16'h0002, 1'b0, lat, z, bok);
        start = 1'b1; A = 16'h0009; B = 16'h0002; P = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({Z_out, busy, done} !== 3'b000) begin
            failures++; $display("FAIL abort_outputs: got Z/busy/done=%b expected 000", {Z_out, busy, done});
        end
        rst = 1'b0;
        spurious = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin failures++; $display("FAIL abort_no_done: got activity=%b expected 0", spurious); end
        do_cmp(16'h0100, 16'h00FF, 1'b0, lat, z, bok);
        checks++;
        if (z !== 1'b1 || lat !== N) begin
            failures++; $display("FAIL after_abort: got z=%b lat=%0d expected z=1 lat=%0d", z, lat, N);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic z, bok;
        do_cmp(16'h0001, 16'h0002, 1'b1, lat, z, bok);
        checks++;
        if (z !== 1'b0) begin failures++; $display("FAIL b2b_first: got %b expected 0", z); end
        // Now sitting in the done cycle; the next start must be accepted immediately.
        do_cmp(16'hA000, 16'h9FFF, 1'b0, lat, z, bok);
        checks++;
        if (z !== 1'b1 || lat !== N || bok !== 1'b1) begin
            failures++; $display("FAIL b2b_second: got z=%b lat=%0d busy_ok=%b expected z=1 lat=%0d busy_ok=1", z, lat, bok, N);
        end
    endtask

    task automatic test_random();
        int lat; logic z, bok;
        logic [N-1:0] ra, rb;
        logic expz;
        for (int k = 0; k < 10; k++) begin
            ra = N'($urandom);
            rb = (k == 3) ? ra : N'($urandom);
            expz = (ra > rb);
            do_cmp(ra, rb, expz, lat, z, bok);
            checks++;
            if (z !== expz || lat !== N) begin
                failures++;
                $display("FAIL random_%0d: A=%h B=%h got z=%b lat=%0d expected z=%b lat=%0d", k, ra, rb, z, lat, expz, N);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; P = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_p_override();
        test_equal();
        test_msb();
        test_ignore_restart();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
